// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks the PC through instruction memory and
// hands fetched words to decode, steering on branches, jumps and traps.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] TRAP_VEC = 32'h00000100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        trap,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] instr_pc,
  output logic        misalign
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        misalign_q, misalign_d;

  logic        redir_any;
  logic        redir_bad;
  logic [31:0] redir_target;
  logic        complete;

  always_comb begin
    redir_any    = trap | redirect_valid;
    redir_bad    = !trap && redirect_valid && (redirect_pc[1:0] != 2'b00);
    redir_target = (trap || redir_bad) ? TRAP_VEC : redirect_pc;
    complete     = req_q & imem_ready;

    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = 1'b0;
    misalign_d    = 1'b0;

    case (state_q)
      BOOT: begin
        state_d = FETCH;
        pc_d    = RESET_PC;
      end
      FETCH: begin
        if (complete && !redir_any) begin
          instr_d       = imem_rdata;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          pc_d          = pc_q + 32'd4;
          state_d       = stall ? HOLD : FETCH;
        end else if (redir_any) begin
          // A response arriving alongside a redirect belongs to the old path.
          pc_d       = redir_target;
          misalign_d = redir_bad;
          state_d    = complete ? FETCH : DRAIN;
        end
      end
      HOLD: begin
        if (redir_any) begin
          pc_d       = redir_target;
          misalign_d = redir_bad;
        end
        if (!stall) state_d = FETCH;
      end
      DRAIN: begin
        if (redir_any) begin
          pc_d       = redir_target;
          misalign_d = redir_bad;
        end
        if (complete) state_d = FETCH;
      end
      default: state_d = BOOT;
    endcase

    // The outstanding request keeps its address until memory takes it.
    addr_d = (state_d == DRAIN) ? addr_q : pc_d;
    req_d  = (state_d == FETCH) || (state_d == DRAIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      addr_q        <= RESET_PC;
      req_q         <= 1'b0;
      instr_q       <= 32'h0;
      instr_pc_q    <= 32'h0;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      addr_q        <= addr_d;
      req_q         <= req_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      misalign_q    <= misalign_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a vector table for the default-parameter
// instance plus a short hand sequence for a PC that wraps past 2^32.
module tb_fetch_sequencer;

  localparam logic [31:0] K = 32'hA5A5A5A5;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        trap;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic        e_iv;
    logic [31:0] e_ipc;
    logic [31:0] e_instr;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];
  int   vec_count  = 0;
  int   miscompares = 0;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid, trap, imem_ready;
  logic [31:0] redirect_pc;
  logic        imem_req, instr_valid, misalign;
  logic [31:0] imem_addr, imem_rdata, pc, instr, instr_pc;

  logic        rst2, ready2;
  logic        req2, iv2, mis2;
  logic [31:0] addr2, rdata2, pc2, instr2, ipc2;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ K;
  assign rdata2     = addr2 ^ K;

  fetch_sequencer u_dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .trap(trap), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .pc(pc), .instr(instr), .instr_valid(instr_valid), .instr_pc(instr_pc),
    .misalign(misalign)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFFFFFC), .TRAP_VEC(32'h00000100)) u_wrap (
    .clk(clk), .rst(rst2), .stall(1'b0), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .trap(1'b0), .imem_req(req2),
    .imem_addr(addr2), .imem_ready(ready2), .imem_rdata(rdata2),
    .pc(pc2), .instr(instr2), .instr_valid(iv2), .instr_pc(ipc2),
    .misalign(mis2)
  );

  task automatic addVec(input logic r, input logic s, input logic rv, input logic [31:0] rpc,
                        input logic tr, input logic rdy, input logic e_req, input logic [31:0] e_addr,
                        input logic [31:0] e_pc, input logic e_iv, input logic [31:0] e_ipc,
                        input logic [31:0] e_instr, input logic e_mis);
    vec_t v;
    v.rst = r; v.stall = s; v.rv = rv; v.rpc = rpc; v.trap = tr; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_pc = e_pc; v.e_iv = e_iv;
    v.e_ipc = e_ipc; v.e_instr = e_instr; v.e_mis = e_mis;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    rst            = v.rst;
    stall          = v.stall;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    trap           = v.trap;
    imem_ready     = v.rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    bit bad = 0;
    vec_count++;
    if (imem_req !== v.e_req) begin
      $display("[TB] FAIL vec%0d imem_req: got %b want %b", idx, imem_req, v.e_req); bad = 1;
    end
    if ((v.e_req || v.rst) && imem_addr !== v.e_addr) begin
      $display("[TB] FAIL vec%0d imem_addr: got %h want %h", idx, imem_addr, v.e_addr); bad = 1;
    end
    if (pc !== v.e_pc) begin
      $display("[TB] FAIL vec%0d pc: got %h want %h", idx, pc, v.e_pc); bad = 1;
    end
    if (instr_valid !== v.e_iv) begin
      $display("[TB] FAIL vec%0d instr_valid: got %b want %b", idx, instr_valid, v.e_iv); bad = 1;
    end
    if (instr_pc !== v.e_ipc) begin
      $display("[TB] FAIL vec%0d instr_pc: got %h want %h", idx, instr_pc, v.e_ipc); bad = 1;
    end
    if (instr !== v.e_instr) begin
      $display("[TB] FAIL vec%0d instr: got %h want %h", idx, instr, v.e_instr); bad = 1;
    end
    if (misalign !== v.e_mis) begin
      $display("[TB] FAIL vec%0d misalign: got %b want %b", idx, misalign, v.e_mis); bad = 1;
    end
    if (bad) miscompares++;
  endtask

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] want);
    vec_count++;
    if (got !== want) begin
      $display("[TB] FAIL %s: got %h want %h", name, got, want);
      miscompares++;
    end
  endtask

  initial begin
    int waited;
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    trap = 1'b0; imem_ready = 1'b0;
    rst2 = 1'b1; ready2 = 1'b1;

    //      rst s rv rpc       tr rdy   req addr      pc        iv ipc       instr        mis
    addVec(1, 0, 0, 32'h0,    0, 0,    0, 32'h0,    32'h0,    0, 32'h0,    32'h0,       0);
    addVec(0, 0, 0, 32'h0,    1, 1,    1, 32'h0,    32'h0,    0, 32'h0,    32'h0,       0);
    addVec(0, 0, 0, 32'h0,    0, 1,    1, 32'h4,    32'h4,    1, 32'h0,    32'h0^K,     0);
    addVec(0, 0, 0, 32'h0,    0, 1,    1, 32'h8,    32'h8,    1, 32'h4,    32'h4^K,     0);
    addVec(0, 0, 0, 32'h0,    0, 1,    1, 32'hC,    32'hC,    1, 32'h8,    32'h8^K,     0);
    addVec(0, 0, 0, 32'h0,    0, 1,    1, 32'h10,   32'h10,   1, 32'hC,    32'hC^K,     0);
    addVec(0, 0, 1, 32'h40,   0, 0,    1, 32'h10,   32'h40,   0, 32'hC,    32'hC^K,     0);
    addVec(0, 0, 0, 32'h0,    0, 0,    1, 32'h10,   32'h40,   0, 32'hC,    32'hC^K,     0);
    addVec(0, 0, 0, 32'h0,    0, 1,    1, 32'h40,   32'h40,   0, 32'hC,    32'hC^K,     0);
    addVec(0, 0, 0, 32'h0,    0, 1,    1, 32'h44,   32'h44,   1, 32'h40,   32'h40^K,    0);
    addVec(0, 0, 1, 32'h200,  1, 0,    1, 32'h44,   32'h100,  0, 32'h40,   32'h40^K,    0);
    addVec(0, 0, 1, 32'h202,  0, 0,    1, 32'h44,   32'h100,  0, 32'h40,   32'h40^K,    1);
    addVec(0, 0, 0, 32'h0,    0, 1,    1, 32'h100,  32'h100,  0, 32'h40,   32'h40^K,    0);
    addVec(0, 1, 1, 32'h8,    0, 1,    1, 32'h8,    32'h8,    0, 32'h40,   32'h40^K,    0);
    addVec(0, 0, 0, 32'h0,    0, 0,    1, 32'h8,    32'h8,    0, 32'h40,   32'h40^K,    0);
    addVec(0, 0, 0, 32'h0,    0, 0,    1, 32'h8,    32'h8,    0, 32'h40,   32'h40^K,    0);
    addVec(0, 0, 0, 32'h0,    0, 0,    1, 32'h8,    32'h8,    0, 32'h40,   32'h40^K,    0);
    addVec(0, 0, 0, 32'h0,    0, 1,    1, 32'hC,    32'hC,    1, 32'h8,    32'h8^K,     0);
    addVec(0, 0, 1, 32'h20,   0, 1,    1, 32'h20,   32'h20,   0, 32'h8,    32'h8^K,     0);
    addVec(0, 1, 0, 32'h0,    0, 1,    0, 32'h0,    32'h24,   1, 32'h20,   32'h20^K,    0);
    addVec(0, 1, 0, 32'h0,    0, 1,    0, 32'h0,    32'h24,   0, 32'h20,   32'h20^K,    0);
    addVec(0, 0, 0, 32'h0,    0, 1,    1, 32'h24,   32'h24,   0, 32'h20,   32'h20^K,    0);
    addVec(0, 0, 0, 32'h0,    0, 1,    1, 32'h28,   32'h28,   1, 32'h24,   32'h24^K,    0);
    addVec(0, 1, 0, 32'h0,    0, 1,    0, 32'h0,    32'h2C,   1, 32'h28,   32'h28^K,    0);
    addVec(0, 1, 1, 32'h60,   0, 1,    0, 32'h0,    32'h60,   0, 32'h28,   32'h28^K,    0);
    addVec(0, 0, 0, 32'h0,    0, 1,    1, 32'h60,   32'h60,   0, 32'h28,   32'h28^K,    0);
    addVec(0, 0, 0, 32'h0,    0, 1,    1, 32'h64,   32'h64,   1, 32'h60,   32'h60^K,    0);
    addVec(0, 0, 0, 32'h0,    1, 0,    1, 32'h64,   32'h100,  0, 32'h60,   32'h60^K,    0);
    addVec(1, 0, 0, 32'h0,    0, 1,    0, 32'h0,    32'h0,    0, 32'h0,    32'h0,       0);
    addVec(0, 0, 0, 32'h0,    0, 0,    1, 32'h0,    32'h0,    0, 32'h0,    32'h0,       0);
    addVec(0, 0, 1, 32'h13,   0, 0,    1, 32'h0,    32'h100,  0, 32'h0,    32'h0,       1);
    addVec(0, 0, 0, 32'h0,    0, 1,    1, 32'h100,  32'h100,  0, 32'h0,    32'h0,       0);
    addVec(0, 0, 0, 32'h0,    0, 1,    1, 32'h104,  32'h104,  1, 32'h100,  32'h100^K,   0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i]);
    end

    // Wrap-around instance: reset value, then 0xFFFFFFFC followed by 0x0.
    @(posedge clk); #1;
    checkValue("wrap reset pc", pc2, 32'hFFFFFFFC);
    checkValue("wrap reset req", {31'h0, req2}, 32'h0);
    rst2 = 1'b0;
    @(posedge clk); #1;
    checkValue("wrap first req", {31'h0, req2}, 32'h1);
    checkValue("wrap first addr", addr2, 32'hFFFFFFFC);
    @(posedge clk); #1;
    checkValue("wrap iv0", {31'h0, iv2}, 32'h1);
    checkValue("wrap ipc0", ipc2, 32'hFFFFFFFC);
    checkValue("wrap instr0", instr2, 32'hFFFFFFFC ^ K);
    checkValue("wrap pc after top", pc2, 32'h0);
    @(posedge clk); #1;
    checkValue("wrap ipc1", ipc2, 32'h0);
    checkValue("wrap instr1", instr2, K);

    // Memory back-pressure on the wrap instance, then a bounded wait for data.
    ready2 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checkValue("stall req", {31'h0, req2}, 32'h1);
      checkValue("stall addr", addr2, 32'h4);
      checkValue("stall iv", {31'h0, iv2}, 32'h0);
    end
    ready2 = 1'b1;
    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (!iv2 && waited < 5);
    checkValue("resume latency", waited, 32'd1);
    checkValue("resume ipc", ipc2, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-002 Parameter TRAP_VEC, default 32'h00000100, redirect target on trap or misaligned redirect.
REQ-003 clk  input  1  single clock, all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 stall  input  1  decode cannot accept; sampled only on fetch completion.
REQ-006 redirect_valid  input  1  branch/jump taken this cycle.
REQ-007 redirect_pc  input  32  branch/jump target.
REQ-008 trap  input  1  exception request; overrides redirect.
REQ-009 imem_req  output  1  fetch request to instruction memory.
REQ-010 imem_addr  output  32  fetch address, stable while imem_req=1 and imem_ready=0.
REQ-011 imem_ready  input  1  memory accepts and returns data this cycle.
REQ-012 imem_rdata  input  32  instruction word, valid when imem_req&imem_ready.
REQ-013 pc  output  32  address of next instruction to be delivered (next-PC register).
REQ-014 instr  output  32  last delivered instruction word.
REQ-015 instr_valid  output  1  one-cycle pulse, instr/instr_pc newly valid.
REQ-016 instr_pc  output  32  address of instr.
REQ-017 misalign  output  1  one-cycle pulse, redirect_pc[1:0]!=0 detected.

Function
REQ-018 FSM states SHALL be BOOT, FETCH, HOLD, DRAIN; completion means imem_req&imem_ready in the same cycle.
REQ-019 BOOT: imem_req=0; next cycle SHALL go FETCH with pc=imem_addr=RESET_PC.
REQ-020 FETCH: imem_req=1, imem_addr=pc; imem_req SHALL NOT deassert until completion.
REQ-021 Redirect target priority: trap -> TRAP_VEC; else redirect_valid with redirect_pc[1:0]!=0 -> TRAP_VEC plus misalign pulse next cycle; else redirect_valid -> redirect_pc.
REQ-022 FETCH, completion, no trap/redirect: instr<=imem_rdata, instr_pc<=pc, instr_valid=1 next cycle, pc<=pc+4 (mod 2^32, 32'hFFFFFFFC wraps to 0); next state HOLD if stall=1 else FETCH.
REQ-023 FETCH, completion with trap/redirect same cycle: response discarded (no instr_valid), pc<=target, stay FETCH (stall ignored).
REQ-024 FETCH, no completion, trap/redirect: pc<=target, imem_addr held at old address, go DRAIN.
REQ-025 DRAIN: imem_req=1 at old address; on completion discard data, go FETCH with imem_addr=pc; further trap/redirect in DRAIN SHALL update pc only (latest wins).
REQ-026 HOLD: imem_req=0, pc held; trap/redirect updates pc; stall=0 -> FETCH next cycle.
REQ-027 instr and instr_pc SHALL hold value between instr_valid pulses.
REQ-028 Throughput: with imem_ready=1 constant and no stall, one instr_valid every cycle.
REQ-029 Redirect/trap inputs SHALL be ignored in BOOT.

Reset
REQ-030 rst=1 at a posedge SHALL force state BOOT, pc=imem_addr=RESET_PC, imem_req=0, instr=0, instr_pc=0, instr_valid=0, misalign=0, overriding all other inputs including an in-flight fetch (outstanding response dropped).
REQ-031 First imem_req SHALL assert the 2nd cycle after rst deasserts.

Verification
REQ-032 Reset release, imem_ready=1 always, imem_rdata=addr^32'hA5A5A5A5 -> instr_pc 0,4,8,12 on consecutive cycles, matching rdata.
REQ-033 imem_ready low 3 cycles at addr 0x8 -> imem_req and imem_addr=0x8 stable 3 cycles, one instr_valid on 4th.
REQ-034 redirect_valid=1, redirect_pc=0x40 while fetch at 0x10 pending, ready 2 cycles later -> DRAIN, 0x10 data discarded, next imem_addr=0x40, next instr_pc=0x40.
REQ-035 trap=1 and redirect_valid=1 (pc 0x200) same cycle -> pc=0x100; redirect_pc=0x202 alone -> misalign pulse, pc=0x100.
REQ-036 stall=1 at completion of 0x20 -> instr_valid once, HOLD, imem_req=0, pc=0x24 until stall=0, then fetch 0x24.
REQ-037 RESET_PC=32'hFFFFFFFC -> instr_pc 0xFFFFFFFC then 0x00000000; rst=1 mid-DRAIN -> BOOT, no instr_valid.
